// File: rtl/fp_result_collector.sv
// ---------------------------------------------------------------------------
// fp_result_collector
//
// Collects single-cycle result pulses from the FP execution sub-units
// (sign-inject, compare/classify, convert, div/sqrt). Each unit has a
// one-entry holding slot. A round-robin arbiter picks one occupied slot per
// cycle and moves it into a registered valid/ready writeback stage.
//
// Ports:
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_unit_valid   per-unit result-valid pulse
//   i_unit_result  packed results, unit i at [32*i +: 32]
//   i_unit_rd      packed destination tags, unit i at [RD_W*i +: RD_W]
//   i_unit_flags   packed fflags, unit i at [FLAGS_W*i +: FLAGS_W]
//   o_unit_full    slot i occupied (registered); dispatch holds unit i off
//   o_wb_valid     writeback entry valid
//   o_wb_result    writeback data
//   o_wb_rd        writeback destination tag
//   o_wb_flags     writeback fflags
//   o_wb_unit      index of the unit that produced the entry
//   i_wb_ready     writeback accepts the presented entry this cycle
//   o_overflow     sticky: a result arrived at a full, ungranted slot
// ---------------------------------------------------------------------------
module fp_result_collector #(
    parameter int NUM_UNITS = 4,
    parameter int RD_W      = 5,
    parameter int FLAGS_W   = 5,
    parameter int IDX_W     = $clog2(NUM_UNITS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_UNITS-1:0]         i_unit_valid,
    input  logic [NUM_UNITS*32-1:0]      i_unit_result,
    input  logic [NUM_UNITS*RD_W-1:0]    i_unit_rd,
    input  logic [NUM_UNITS*FLAGS_W-1:0] i_unit_flags,
    output logic [NUM_UNITS-1:0]         o_unit_full,
    output logic                         o_wb_valid,
    output logic [31:0]                  o_wb_result,
    output logic [RD_W-1:0]              o_wb_rd,
    output logic [FLAGS_W-1:0]           o_wb_flags,
    output logic [IDX_W-1:0]             o_wb_unit,
    input  logic                         i_wb_ready,
    output logic                         o_overflow
);

    // Holding slots
    logic [NUM_UNITS-1:0] slot_valid_q, slot_valid_d;
    logic [31:0]          slot_result_q [NUM_UNITS];
    logic [31:0]          slot_result_d [NUM_UNITS];
    logic [RD_W-1:0]      slot_rd_q     [NUM_UNITS];
    logic [RD_W-1:0]      slot_rd_d     [NUM_UNITS];
    logic [FLAGS_W-1:0]   slot_flags_q  [NUM_UNITS];
    logic [FLAGS_W-1:0]   slot_flags_d  [NUM_UNITS];

    // Output stage
    logic                 wb_valid_q,  wb_valid_d;
    logic [31:0]          wb_result_q, wb_result_d;
    logic [RD_W-1:0]      wb_rd_q,     wb_rd_d;
    logic [FLAGS_W-1:0]   wb_flags_q,  wb_flags_d;
    logic [IDX_W-1:0]     wb_unit_q,   wb_unit_d;

    // Arbitration and status
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 overflow_q, overflow_d;

    logic                 can_load;
    logic                 grant_any;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_UNITS-1:0] grant_vec;

    // Round-robin search starting at ptr_q; the modulo handles
    // non-power-of-two unit counts.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        can_load  = !wb_valid_q || i_wb_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        if (can_load) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                cand     = (int'(ptr_q) + k) % NUM_UNITS;
                cand_idx = IDX_W'(cand);
                if (!grant_any && slot_valid_q[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Slot capture / release. A slot being granted this edge is free to take
    // a new pulse, so grant-and-capture on the same slot is not an overflow.
    always_comb begin
        slot_valid_d  = slot_valid_q;
        slot_result_d = slot_result_q;
        slot_rd_d     = slot_rd_q;
        slot_flags_d  = slot_flags_q;
        overflow_d    = overflow_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (i_unit_valid[i] && (!slot_valid_q[i] || grant_vec[i])) begin
                slot_valid_d[i]  = 1'b1;
                slot_result_d[i] = i_unit_result[32*i +: 32];
                slot_rd_d[i]     = i_unit_rd[RD_W*i +: RD_W];
                slot_flags_d[i]  = i_unit_flags[FLAGS_W*i +: FLAGS_W];
            end else if (grant_vec[i]) begin
                slot_valid_d[i] = 1'b0;
            end
            if (i_unit_valid[i] && slot_valid_q[i] && !grant_vec[i]) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Output register and pointer update. Data holds when the stage drains
    // without a new grant; only valid drops.
    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_flags_d  = wb_flags_q;
        wb_unit_d   = wb_unit_q;
        ptr_d       = ptr_q;
        if (can_load) begin
            wb_valid_d = grant_any;
            if (grant_any) begin
                wb_result_d = slot_result_q[grant_idx];
                wb_rd_d     = slot_rd_q[grant_idx];
                wb_flags_d  = slot_flags_q[grant_idx];
                wb_unit_d   = grant_idx;
            end
        end
        if (grant_any) begin
            ptr_d = (int'(grant_idx) == NUM_UNITS - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Control and output-stage state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot_valid_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_result_q  <= '0;
            wb_rd_q      <= '0;
            wb_flags_q   <= '0;
            wb_unit_q    <= '0;
            ptr_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            wb_valid_q   <= wb_valid_d;
            wb_result_q  <= wb_result_d;
            wb_rd_q      <= wb_rd_d;
            wb_flags_q   <= wb_flags_d;
            wb_unit_q    <= wb_unit_d;
            ptr_q        <= ptr_d;
            overflow_q   <= overflow_d;
        end
    end

    // Slot payload is qualified by slot_valid_q and needs no reset
    always_ff @(posedge i_clk) begin
        slot_result_q <= slot_result_d;
        slot_rd_q     <= slot_rd_d;
        slot_flags_q  <= slot_flags_d;
    end

    assign o_unit_full = slot_valid_q;
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_result = wb_result_q;
    assign o_wb_rd     = wb_rd_q;
    assign o_wb_flags  = wb_flags_q;
    assign o_wb_unit   = wb_unit_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// ---------------------------------------------------------------------------
// Testbench for fp_result_collector (NUM_UNITS=4, RD_W=5, FLAGS_W=5).
// Directed table, hand-written corner sequences, and randomized traffic
// checked against a behavioural model of slots, round-robin and output stage.
// ---------------------------------------------------------------------------
module tb_fp_result_collector;

    localparam int N  = 4;
    localparam int RW = 5;
    localparam int FW = 5;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    uv;
    logic [N*32-1:0] ures;
    logic [N*RW-1:0] urd;
    logic [N*FW-1:0] ufl;
    logic            rdy;
    logic [N-1:0]    full;
    logic            wbv;
    logic [31:0]     wres;
    logic [RW-1:0]   wrd;
    logic [FW-1:0]   wfl;
    logic [IW-1:0]   wunit;
    logic            ovf;

    int checks = 0;
    int errors = 0;

    fp_result_collector #(.NUM_UNITS(N), .RD_W(RW), .FLAGS_W(FW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_unit_valid(uv), .i_unit_result(ures),
        .i_unit_rd(urd), .i_unit_flags(ufl), .o_unit_full(full),
        .o_wb_valid(wbv), .o_wb_result(wres), .o_wb_rd(wrd), .o_wb_flags(wfl),
        .o_wb_unit(wunit), .i_wb_ready(rdy), .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] vld;
        logic         rdy;
        logic         exp_v;
        int           exp_u;
        logic [N-1:0] exp_full;
    } vec_t;

    vec_t tbl [13];

    // Behavioural reference state
    bit          m_full [N];
    logic [31:0] m_res  [N];
    logic [4:0]  m_rd   [N];
    logic [4:0]  m_fl   [N];
    int          m_ptr;
    bit          m_wbv;
    logic [31:0] m_wres;
    logic [4:0]  m_wrd, m_wfl;
    int          m_wu;
    bit          m_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_unit(int i, logic [31:0] r, logic [4:0] d, logic [4:0] f);
        ures[32*i +: 32] = r;
        urd[RW*i +: RW]  = d;
        ufl[FW*i +: FW]  = f;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uv    = '0;
        rdy   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_ptr = 0; m_wbv = 0; m_ovf = 0; m_wres = 0; m_wrd = 0; m_wfl = 0; m_wu = 0;
        for (int i = 0; i < N; i++) m_full[i] = 0;
    endtask

    // One clock of the reference: arbitrate among held entries, retire or
    // load the output, then capture new pulses into free or freed slots.
    task automatic model_step();
        bit can;
        int g;
        can = !m_wbv || rdy;
        g   = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_full[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            m_wbv = (g >= 0);
            if (g >= 0) begin
                m_wres = m_res[g]; m_wrd = m_rd[g]; m_wfl = m_fl[g]; m_wu = g;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (uv[i]) begin
                if (!m_full[i] || i == g) begin
                    m_full[i] = 1;
                    m_res[i]  = ures[32*i +: 32];
                    m_rd[i]   = urd[RW*i +: RW];
                    m_fl[i]   = ufl[FW*i +: FW];
                end else begin
                    m_ovf = 1;
                end
            end else if (i == g) begin
                m_full[i] = 0;
            end
        end
        if (g >= 0) m_ptr = (g + 1) % N;
    endtask

    task automatic cmp_model(int cyc);
        logic [N-1:0] ef;
        for (int i = 0; i < N; i++) ef[i] = m_full[i];
        chk($sformatf("rnd%0d full", cyc), 32'(full), 32'(ef));
        chk($sformatf("rnd%0d wbv", cyc), 32'(wbv), 32'(m_wbv));
        chk($sformatf("rnd%0d ovf", cyc), 32'(ovf), 32'(m_ovf));
        if (m_wbv) begin
            chk($sformatf("rnd%0d res", cyc), wres, m_wres);
            chk($sformatf("rnd%0d rd", cyc), 32'(wrd), 32'(m_wrd));
            chk($sformatf("rnd%0d fl", cyc), 32'(wfl), 32'(m_wfl));
            chk($sformatf("rnd%0d unit", cyc), 32'(wunit), 32'(m_wu));
        end
    endtask

    initial begin
        rst_n = 1'b0; uv = '0; rdy = 1'b0; ures = '0; urd = '0; ufl = '0;

        // Directed round-robin table, ready held high
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 0, 4'b1111};
        tbl[1]  = '{4'b0000, 1'b1, 1'b1, 0, 4'b1110};
        tbl[2]  = '{4'b0000, 1'b1, 1'b1, 1, 4'b1100};
        tbl[3]  = '{4'b0000, 1'b1, 1'b1, 2, 4'b1000};
        tbl[4]  = '{4'b0000, 1'b1, 1'b1, 3, 4'b0000};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
        tbl[6]  = '{4'b1010, 1'b1, 1'b0, 0, 4'b1010};
        tbl[7]  = '{4'b0001, 1'b1, 1'b1, 1, 4'b1001};
        tbl[8]  = '{4'b0000, 1'b1, 1'b1, 3, 4'b0001};
        tbl[9]  = '{4'b0000, 1'b1, 1'b1, 0, 4'b0000};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
        tbl[11] = '{4'b1111, 1'b1, 1'b0, 0, 4'b1111};
        tbl[12] = '{4'b0000, 1'b1, 1'b1, 1, 4'b1101};

        do_reset();
        chk("rst full", 32'(full), 0);
        chk("rst wbv", 32'(wbv), 0);
        chk("rst res", wres, 0);
        chk("rst rd", 32'(wrd), 0);
        chk("rst unit", 32'(wunit), 0);
        chk("rst ovf", 32'(ovf), 0);

        for (int i = 0; i < N; i++) set_unit(i, 32'h4000_0000 + i, 5'(i + 1), 5'(i));
        for (int r = 0; r < 13; r++) begin
            uv  = tbl[r].vld;
            rdy = tbl[r].rdy;
            tick();
            chk($sformatf("tbl%0d full", r), 32'(full), 32'(tbl[r].exp_full));
            chk($sformatf("tbl%0d wbv", r), 32'(wbv), 32'(tbl[r].exp_v));
            chk($sformatf("tbl%0d ovf", r), 32'(ovf), 0);
            if (tbl[r].exp_v) begin
                chk($sformatf("tbl%0d unit", r), 32'(wunit), 32'(tbl[r].exp_u));
                chk($sformatf("tbl%0d res", r), wres, 32'h4000_0000 + 32'(tbl[r].exp_u));
                chk($sformatf("tbl%0d rd", r), 32'(wrd), 32'(tbl[r].exp_u + 1));
                chk($sformatf("tbl%0d fl", r), 32'(wfl), 32'(tbl[r].exp_u));
            end
        end
        uv = '0;

        // Single result latency
        do_reset();
        rdy = 1'b1;
        set_unit(0, 32'h3F80_0000, 5'd3, 5'd0);
        uv = 4'b0001; tick(); uv = '0;
        chk("lat full0 T+1", 32'(full[0]), 1);
        chk("lat wbv T+1", 32'(wbv), 0);
        tick();
        chk("lat wbv T+2", 32'(wbv), 1);
        chk("lat res", wres, 32'h3F80_0000);
        chk("lat rd", 32'(wrd), 3);
        chk("lat unit", 32'(wunit), 0);
        chk("lat full0 T+2", 32'(full[0]), 0);

        // Output stall: entry held stable, retires once
        do_reset();
        set_unit(2, 32'hC000_0000, 5'd7, 5'd2);
        uv = 4'b0100; tick(); uv = '0;
        tick();
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("stall%0d wbv", s), 32'(wbv), 1);
            chk($sformatf("stall%0d res", s), wres, 32'hC000_0000);
            chk($sformatf("stall%0d rd", s), 32'(wrd), 7);
            chk($sformatf("stall%0d fl", s), 32'(wfl), 2);
            chk($sformatf("stall%0d unit", s), 32'(wunit), 2);
            tick();
        end
        rdy = 1'b1;
        tick();
        chk("stall retire once", 32'(wbv), 0);

        // Overflow on a full, stalled slot
        do_reset();
        set_unit(1, 32'hAAAA_0001, 5'd5, 5'd1);
        uv = 4'b0010; tick(); uv = '0;
        tick();
        chk("ovf first in out", wres, 32'hAAAA_0001);
        set_unit(1, 32'hBBBB_0002, 5'd6, 5'd0);
        uv = 4'b0010; tick(); uv = '0;
        chk("ovf none yet", 32'(ovf), 0);
        set_unit(1, 32'h1234_5678, 5'd7, 5'd0);
        uv = 4'b0010; tick(); uv = '0;
        chk("ovf set", 32'(ovf), 1);
        chk("ovf slot still full", 32'(full[1]), 1);
        rdy = 1'b1;
        tick();
        chk("ovf orig retires", wres, 32'hBBBB_0002);
        chk("ovf orig rd", 32'(wrd), 6);
        chk("ovf sticky", 32'(ovf), 1);
        tick();
        chk("ovf drained", 32'(wbv), 0);
        chk("ovf sticky2", 32'(ovf), 1);
        chk("ovf dropped never seen", 32'(wres == 32'h1234_5678), 0);

        // Grant and new pulse on the same slot in the same cycle
        do_reset();
        rdy = 1'b1;
        set_unit(3, 32'h3333_0008, 5'd8, 5'd0);
        uv = 4'b1000; tick(); uv = '0;
        set_unit(3, 32'h3333_0009, 5'd9, 5'd0);
        uv = 4'b1000; tick(); uv = '0;
        chk("gc wb rd8", 32'(wrd), 8);
        chk("gc unit", 32'(wunit), 3);
        chk("gc full3", 32'(full[3]), 1);
        chk("gc no ovf", 32'(ovf), 0);
        tick();
        chk("gc wbv rd9", 32'(wbv), 1);
        chk("gc rd9", 32'(wrd), 9);
        chk("gc full3 clr", 32'(full[3]), 0);
        tick();
        chk("gc drained", 32'(wbv), 0);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < N; i++) set_unit(i, 32'h5000_0000 + i, 5'(i + 10), 5'(i));
        uv = 4'b1111; tick(); uv = '0;
        tick();
        chk("mr pre full", 32'(full), 32'hE);
        uv = 4'b0010; tick(); uv = '0;
        chk("mr pre ovf", 32'(ovf), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mr full", 32'(full), 0);
        chk("mr wbv", 32'(wbv), 0);
        chk("mr ovf", 32'(ovf), 0);
        chk("mr res", wres, 0);
        chk("mr unit", 32'(wunit), 0);
        rdy = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("mr stale%0d", s), 32'(wbv), 0);
        end

        // Randomized traffic against the reference
        do_reset();
        for (int c = 0; c < 400; c++) begin
            uv  = 4'($urandom) & 4'($urandom);
            rdy = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) set_unit(i, $urandom, 5'($urandom), 5'($urandom));
            model_step();
            tick();
            cmp_model(c);
        end
        uv = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
